// File: rtl/dac_stream_play.sv
// dac_stream_play: AXI-Stream sample playback into a 16-bit serial DAC.
// Samples from DMA MM2S are buffered in a synchronous FIFO, then shifted out MSB first
// in 34-cycle frames, one frame every max(rate_div, 34) clocks.
// Optional build macro DAC_OFFSET_BINARY_EN: invert each sample MSB before shifting
// (two's complement to offset binary). Undefined: samples are shifted unmodified.
module dac_stream_play #(
  parameter int unsigned FIFO_AW     = 6,
  parameter int unsigned PRIME_LEVEL = 32
) (
  input  logic               dac_clk,
  input  logic               dac_rst,
  output logic               dac_CS_n,
  output logic               dac_SCK,
  output logic               dac_SDI,
  input  logic [31:0]        play_len,
  input  logic [15:0]        rate_div,
  input  logic               play_start,
  input  logic               play_abort,
  output logic               play_busy,
  output logic               play_done,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level,
  input  logic [15:0]        DMA_AXIS_tdata,
  input  logic [1:0]         DMA_AXIS_tkeep,
  input  logic               DMA_AXIS_tlast,
  input  logic               DMA_AXIS_tvalid,
  output logic               DMA_AXIS_tready
);

  localparam int unsigned Depth      = 2 ** FIFO_AW;
  localparam int unsigned PrimeClamp = (PRIME_LEVEL > Depth) ? Depth : PRIME_LEVEL;
  localparam logic [31:0] PrimeThr   = 32'(PrimeClamp);
  localparam logic [15:0] MinRate    = 16'd34;
  localparam logic [5:0]  FrameLast  = 6'd33;
  localparam logic [FIFO_AW-1:0] PtrOne = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CntOne = {{FIFO_AW{1'b0}}, 1'b1};

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] WordMask = 16'h8000;
`else
  localparam logic [15:0] WordMask = 16'h0000;
`endif

  typedef enum logic [1:0] {StIdle, StPrime, StPlay, StDone} state_e;

  state_e r_state, w_state_nxt;

  // FIFO storage and pointers
  logic [15:0]        r_mem [Depth];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  // Run control
  logic [31:0] r_len, r_cnt, r_per;
  logic [15:0] r_rate, r_prev;
  logic        r_underrun, r_zero_done;

  // DAC frame shifter
  logic        r_active;
  logic [5:0]  r_k;
  logic [15:0] r_sh;

  logic        w_full, w_empty, w_push, w_pop, w_launch;
  logic        w_prime_ok, w_period_end, w_frame_last;
  logic [15:0] w_rate_eff, w_fifo_word, w_word;
  logic [31:0] w_level32, w_prime_thr;
  logic        w_unused;

  // tkeep/tlast carry no information for this path.
  assign w_unused = ^{DMA_AXIS_tkeep, DMA_AXIS_tlast};

  // Count can reach Depth exactly, so its MSB alone flags full.
  assign w_full          = r_count[FIFO_AW];
  assign w_empty         = (r_count == '0);
  assign DMA_AXIS_tready = ~w_full & ~dac_rst;
  assign w_push          = DMA_AXIS_tvalid & DMA_AXIS_tready;
  assign w_pop           = w_launch & ~w_empty;

  assign w_rate_eff   = (rate_div < MinRate) ? MinRate : rate_div;
  assign w_level32    = {{(31 - FIFO_AW){1'b0}}, r_count};
  assign w_prime_thr  = (r_len < PrimeThr) ? r_len : PrimeThr;
  assign w_prime_ok   = (w_level32 >= w_prime_thr);
  assign w_period_end = (r_per == ({16'd0, r_rate} - 32'd1));
  assign w_frame_last = r_active && (r_k == FrameLast);

  // An empty FIFO at frame start repeats the previous word of this run.
  assign w_fifo_word = r_mem[r_rd_ptr];
  assign w_word      = w_empty ? r_prev : w_fifo_word;

  // Next-state logic; w_launch marks the cycle before a frame's k=0.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (play_start && (play_len != 32'd0)) w_state_nxt = StPrime;
      end
      StPrime: begin
        if (w_prime_ok) begin
          w_state_nxt = StPlay;
          w_launch    = 1'b1;
        end
      end
      StPlay: begin
        if (w_period_end && (r_cnt != r_len)) w_launch = 1'b1;
        if (w_frame_last && (r_cnt == r_len)) w_state_nxt = StDone;
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (play_abort) begin
      w_state_nxt = StIdle;
      w_launch    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  // FIFO data array; flushing only moves pointers, contents are don't-care.
  always_ff @(posedge dac_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= DMA_AXIS_tdata;
  end

  // FIFO pointers and occupancy; abort flushes.
  always_ff @(posedge dac_clk) begin
    if (dac_rst || play_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Run parameters, sample/period counters and underrun flag.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      r_len       <= '0;
      r_rate      <= MinRate;
      r_cnt       <= '0;
      r_per       <= '0;
      r_prev      <= '0;
      r_underrun  <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_zero_done <= 1'b0;
      if (!play_abort) begin
        if ((r_state == StIdle) && play_start) begin
          r_len       <= play_len;
          r_rate      <= w_rate_eff;
          r_cnt       <= '0;
          r_prev      <= '0;
          r_underrun  <= 1'b0;
          r_zero_done <= (play_len == 32'd0);
        end
        if (w_launch) begin
          r_cnt <= r_cnt + 32'd1;
          r_per <= '0;
          if (w_empty) r_underrun <= 1'b1;
          else         r_prev     <= w_fifo_word;
        end else if (r_state == StPlay) begin
          r_per <= r_per + 32'd1;
        end
      end
    end
  end

  // Frame sequencer: k counts 0..33, data shifts on each SCK falling edge.
  always_ff @(posedge dac_clk) begin
    if (dac_rst || play_abort) begin
      r_active <= 1'b0;
      r_k      <= '0;
      r_sh     <= '0;
    end else if (w_launch) begin
      r_active <= 1'b1;
      r_k      <= '0;
      r_sh     <= w_word ^ WordMask;
    end else if (r_active) begin
      if (r_k == FrameLast) begin
        r_active <= 1'b0;
        r_sh     <= '0;
      end else begin
        r_k <= r_k + 6'd1;
        if (r_k[0] && (r_k <= 6'd31)) r_sh <= {r_sh[14:0], 1'b0};
      end
    end
  end

  // Abort forces the DAC lines idle in the same cycle.
  assign dac_CS_n   = ~r_active | (r_k == FrameLast) | play_abort;
  assign dac_SCK    = r_active & r_k[0] & (r_k <= 6'd31) & ~play_abort;
  assign dac_SDI    = r_active & r_sh[15];
  assign play_busy  = (r_state != StIdle);
  assign play_done  = (r_state == StDone) | r_zero_done;
  assign underrun   = r_underrun;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_dac_stream_play.sv
// tb_dac_stream_play: directed and randomized playback runs against a frame-level model.
module tb_dac_stream_play;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs_n, sck, sdi;
  logic [31:0]   play_len;
  logic [15:0]   rate_div;
  logic          play_start, play_abort;
  logic          busy, done, urun;
  logic [AW:0]   level;
  logic [15:0]   tdata;
  logic          tvalid, tready;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  dac_stream_play #(.FIFO_AW(AW), .PRIME_LEVEL(2)) dut (
    .dac_clk         (clk),
    .dac_rst         (rst),
    .dac_CS_n        (cs_n),
    .dac_SCK         (sck),
    .dac_SDI         (sdi),
    .play_len        (play_len),
    .rate_div        (rate_div),
    .play_start      (play_start),
    .play_abort      (play_abort),
    .play_busy       (busy),
    .play_done       (done),
    .underrun        (urun),
    .fifo_level      (level),
    .DMA_AXIS_tdata  (tdata),
    .DMA_AXIS_tkeep  (2'b11),
    .DMA_AXIS_tlast  (1'b0),
    .DMA_AXIS_tvalid (tvalid),
    .DMA_AXIS_tready (tready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: decodes each CS_n-low window into a word sampled on SCK rising edges.
  logic        prev_cs  = 1'b1;
  logic        prev_sck = 1'b0;
  logic [15:0] cur_bits = '0;
  int          cur_nb = 0, cur_start = 0;
  logic [15:0] q_word[$];
  int          q_start[$];
  int          q_nb[$];
  int          done_cnt = 0, done_cyc = -1, last_rise = -1;

  always @(negedge clk) begin
    if (prev_cs && !cs_n) begin
      cur_start <= cyc;
      cur_bits  <= '0;
      cur_nb    <= 0;
    end
    if (!cs_n && sck && !prev_sck) begin
      cur_bits <= {cur_bits[14:0], sdi};
      cur_nb   <= cur_nb + 1;
    end
    if (!prev_cs && cs_n) begin
      q_word.push_back(cur_bits);
      q_start.push_back(cur_start);
      q_nb.push_back(cur_nb);
      last_rise <= cyc;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    prev_cs  <= cs_n;
    prev_sck <= sck;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] enc(input logic [15:0] w);
`ifdef DAC_OFFSET_BINARY_EN
    return w ^ 16'h8000;
`else
    return w;
`endif
  endfunction

  logic [15:0] wq[$];

  task automatic push(input logic [15:0] w);
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = w;
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  task automatic start(input int len, input int rate);
    @(negedge clk);
    play_len   = 32'(len);
    rate_div   = 16'(rate);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
  endtask

  // Pushes the first npush words of wq, plays len samples, checks every frame.
  task automatic play_run(input string tag, input int len, input int rate, input int npush);
    int fbase, dbase, reff, bound, nfr;
    logic [15:0] e;
    fbase = q_word.size();
    dbase = done_cnt;
    for (int i = 0; i < npush; i++) push(wq[i]);
    start(len, rate);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    reff  = (rate < 34) ? 34 : rate;
    bound = len * reff + 200;
    for (int t = 0; t < bound && busy; t++) @(negedge clk);
    @(negedge clk);
    #1;
    check({tag, "_finished"}, 64'(busy), 64'd0);
    nfr = q_word.size() - fbase;
    check({tag, "_frames"}, 64'(nfr), 64'(len));
    for (int i = 0; i < len && i < nfr; i++) begin
      e = (i < npush) ? wq[i] : wq[npush - 1];
      check($sformatf("%s_word%0d", tag, i),
            64'({16'(q_nb[fbase + i]), q_word[fbase + i]}), 64'({16'd16, enc(e)}));
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i),
              64'(q_start[fbase + i] - q_start[fbase + i - 1]), 64'(reff));
    end
    check({tag, "_done_cnt"}, 64'(done_cnt - dbase), 64'd1);
    check({tag, "_done_time"}, 64'(done_cyc - last_rise), 64'd1);
    check({tag, "_underrun"}, 64'(urun), 64'(npush < len));
    check({tag, "_level"}, 64'(level), 64'd0);
  endtask

  initial begin
    int len, npush, rate, fbase, dbase;
    bit seen;
    rst = 1'b1; play_len = '0; rate_div = '0; play_start = 1'b0; play_abort = 1'b0;
    tdata = '0; tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(tready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", 64'(cs_n), 64'd1);
    check("rst_sck", 64'(sck), 64'd0);
    check("rst_sdi", 64'(sdi), 64'd0);
    check("rst_tready_up", 64'(tready), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_underrun", 64'(urun), 64'd0);

    // Basic eight-sample run at rate 40.
    wq.delete();
    for (int i = 1; i <= 8; i++) wq.push_back(16'h8000 + 16'(i));
    play_run("basic", 8, 40, 8);

    // Rate clamp; includes an all-zero word.
    wq.delete();
    wq.push_back(16'h0000);
    wq.push_back(16'($urandom));
    play_run("clamp", 2, 10, 2);

    // Underrun: four samples, two words.
    wq.delete();
    wq.push_back(16'($urandom));
    wq.push_back(16'($urandom));
    play_run("under", 4, 34 + int'($urandom_range(0, 6)), 2);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      len   = int'($urandom_range(1, 12));
      npush = (len < 2) ? len : int'($urandom_range(2, len));
      rate  = int'($urandom_range(0, 60));
      wq.delete();
      for (int i = 0; i < npush; i++) wq.push_back(16'($urandom));
      play_run($sformatf("rand%0d", r), len, rate, npush);
    end

    // Zero-length request.
    start(0, 40);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zero_done_once", 64'(done), 64'd0);

    // FIFO fill while idle, then abort flush.
    @(negedge clk);
    tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tdata = 16'($urandom);
      @(negedge clk);
    end
    check("full_level", 64'(level), 64'd16);
    check("full_tready", 64'(tready), 64'd0);
    tvalid = 1'b0;
    play_abort = 1'b1;
    @(negedge clk);
    play_abort = 1'b0;
    check("flush_level", 64'(level), 64'd0);
    check("flush_tready", 64'(tready), 64'd1);

    // Abort in the middle of a frame.
    wq.delete();
    for (int i = 0; i < 4; i++) push(16'($urandom));
    fbase = q_word.size();
    dbase = done_cnt;
    start(4, 40);
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = sck;
    end
    check("abort_sck_seen", 64'(seen), 64'd1);
    play_abort = 1'b1;
    #1;
    check("abort_cs_n", 64'(cs_n), 64'd1);
    check("abort_sck", 64'(sck), 64'd0);
    @(negedge clk);
    play_abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_level", 64'(level), 64'd0);
    repeat (50) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dbase), 64'd0);
    check("abort_idle_cs", 64'(cs_n), 64'd1);
    check("abort_no_more_frames", 64'(q_word.size() - fbase), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
